// File: rtl/component_pkg.sv
// ---------------------------------------------------------------------------
// component_pkg: shared component-word layout, type codes and responder states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package component_pkg;

  localparam int WIDTH = 230;

  localparam int ID_MSB       = 2;
  localparam int ID_LSB       = 0;
  localparam int TYPE_MSB     = 5;
  localparam int TYPE_LSB     = 3;
  localparam int CURRTEMP_MSB = 69;
  localparam int CURRTEMP_LSB = 6;
  localparam int EXTRA_MSB    = 101;
  localparam int EXTRA_LSB    = 70;
  localparam int NAME_MSB     = 229;
  localparam int NAME_LSB     = 102;
  localparam int ON_BIT       = 101;
  localparam int SPEED_MSB    = 100;
  localparam int SPEED_LSB    = 99;

  typedef enum logic [2:0] {
    TYPE_FAN       = 3'd0,
    TYPE_BOILER    = 3'd1,
    TYPE_SENSOR    = 3'd2,
    TYPE_AC        = 3'd3,
    TYPE_CONDENSER = 3'd4
  } comp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_RESP   = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/component_select.sv
// ---------------------------------------------------------------------------
// component_select: combinational id match over the component words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module component_select #(
  parameter int WIDTH = component_pkg::WIDTH,
  parameter int NCOMP = 5
) (
  input  logic [2:0]       id,
  input  logic [WIDTH-1:0] words [NCOMP],
  output logic             hit,
  output logic [WIDTH-1:0] word
);
  import component_pkg::*;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit  = 1'b0;
    word = '0;
    for (int k = NCOMP - 1; k >= 0; k--) begin
      if (words[k][ID_MSB:ID_LSB] == id) begin
        hit  = 1'b1;
        word = words[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/component_read_responder.sv
// ---------------------------------------------------------------------------
// component_read_responder: serial MSB-first field extraction from a component word
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module component_read_responder #(
  parameter int WIDTH = component_pkg::WIDTH,
  parameter int NCOMP = 5,
  parameter int VALW  = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_id,
  input  logic [7:0]       req_right,
  input  logic [5:0]       req_width,
  input  logic [WIDTH-1:0] comp0,
  input  logic [WIDTH-1:0] comp1,
  input  logic [WIDTH-1:0] comp2,
  input  logic [WIDTH-1:0] comp3,
  input  logic [WIDTH-1:0] comp4,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_id,
  output logic [VALW-1:0]  rsp_value,
  output logic             rsp_err,
  output logic             busy
);
  import component_pkg::*;

  localparam int IDXW = $clog2(WIDTH);

  rd_state_e        state_q, state_d;
  logic             ready_q;
  logic [2:0]       id_q;
  logic [7:0]       right_q;
  logic [5:0]       width_q;
  logic [5:0]       cnt_q;
  logic [VALW-1:0]  acc_q;
  logic             err_q;
  logic [WIDTH-1:0] snap_q;

  logic [WIDTH-1:0] words [NCOMP];
  logic             sel_hit;
  logic [WIDTH-1:0] sel_word;
  logic             lookup_err;
  logic [8:0]       idx;
  logic             idx_hi;
  logic [IDXW-1:0]  idx_lo;
  logic             sh_bit;

  assign words[0] = comp0;
  assign words[1] = comp1;
  assign words[2] = comp2;
  assign words[3] = comp3;
  assign words[4] = comp4;

  component_select #(
    .WIDTH (WIDTH),
    .NCOMP (NCOMP)
  ) u_select (
    .id    (id_q),
    .words (words),
    .hit   (sel_hit),
    .word  (sel_word)
  );

  assign lookup_err = !sel_hit
                   || (width_q == 6'd0)
                   || (int'(width_q) > VALW)
                   || (int'(right_q) > WIDTH - 1)
                   || (({1'b0, right_q} + 9'd1) < {3'b000, width_q});

  // The range check keeps right - i inside the word; the high bit only guards stray values.
  assign idx              = {1'b0, right_q} - {3'b000, cnt_q};
  assign {idx_hi, idx_lo} = idx;
  assign sh_bit           = !idx_hi && snap_q[idx_lo];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid && req_ready) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = lookup_err ? ST_RESP : ST_SHIFT;
      ST_SHIFT:  if (cnt_q == width_q - 6'd1) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      id_q    <= '0;
      right_q <= '0;
      width_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            id_q    <= req_id;
            right_q <= req_right;
            width_q <= req_width;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          err_q <= lookup_err;
          if (!lookup_err) snap_q <= sel_word;
        end
        ST_SHIFT: begin
          acc_q <= {acc_q[VALW-2:0], sh_bit};
          cnt_q <= cnt_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_value = acc_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_component_read_responder.sv
// ---------------------------------------------------------------------------
// tb_component_read_responder: directed vectors with a queued scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_component_read_responder;
  import component_pkg::*;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_id = '0;
  logic [7:0]   req_right = '0;
  logic [5:0]   req_width = '0;
  logic [229:0] comp0, comp1, comp2, comp3, comp4;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [2:0]   rsp_id;
  logic [31:0]  rsp_value;
  logic         rsp_err;
  logic         busy;

  component_read_responder #(.WIDTH(230), .NCOMP(5), .VALW(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_right (req_right),
    .req_width (req_width),
    .comp0     (comp0),
    .comp1     (comp1),
    .comp2     (comp2),
    .comp3     (comp3),
    .comp4     (comp4),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_value (rsp_value),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] value;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latency is in clock periods: the accept period is cycle 0, LOOKUP is cycle 1.
  task automatic send(input logic [2:0] id, input logic [7:0] right, input logic [5:0] width,
                      input logic [31:0] value, input logic err, input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    req_id    = id;
    req_right = right;
    req_width = width;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (expect_rsp) begin
      e.id    = id;
      e.value = value;
      e.err   = err;
      e.acc   = cyc;
      e.lat   = err ? 2 : int'(width) + 2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sb.size() != 0 || busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  bit          taken = 1'b0;
  logic [2:0]  h_id;
  logic [31:0] h_val;
  logic        h_err;
  exp_t        m;

  always @(negedge CLK) begin
    if (!RST_N) begin
      taken = 1'b0;
    end else if (rsp_valid) begin
      if (!taken) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got id %0d value %0h expected none", rsp_id, rsp_value);
        end else begin
          m = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(m.id));
          chk("rsp_value", 64'(rsp_value), 64'(m.value));
          chk("rsp_err", 64'(rsp_err), 64'(m.err));
          chk("latency", 64'(cyc - m.acc + 1), 64'(m.lat));
        end
        taken = 1'b1;
        h_id  = rsp_id;
        h_val = rsp_value;
        h_err = rsp_err;
      end else begin
        chk("hold_id", 64'(rsp_id), 64'(h_id));
        chk("hold_value", 64'(rsp_value), 64'(h_val));
        chk("hold_err", 64'(rsp_err), 64'(h_err));
      end
      if (rsp_ready) taken = 1'b0;
    end
  end

  logic [229:0] comp0_saved;
  logic [229:0] comp1_saved;
  int           n;

  initial begin
    comp0 = '0; comp1 = '0; comp2 = '0; comp3 = '0; comp4 = '0;
    comp0[2:0] = 3'd0; comp0[5:3] = TYPE_FAN;
    comp0[101] = 1'b1; comp0[100:99] = 2'b10;
    comp0[229:102] = {8'h00, "Downstairs Bath"};
    comp1[2:0] = 3'd1; comp1[5:3] = TYPE_BOILER;
    comp2[2:0] = 3'd2; comp2[5:3] = TYPE_SENSOR;
    comp2[69:6] = $realtobits(28.5);
    comp3[2:0] = 3'd3; comp3[5:3] = TYPE_AC;
    comp4[2:0] = 3'd4; comp4[5:3] = TYPE_CONDENSER;

    // Reset values while RST_N is held low.
    #12;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_value", 64'(rsp_value), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    #1 chk("ready_at_release", 64'(req_ready), 64'd0);
    @(posedge CLK); #1;
    chk("ready_after_release", 64'(req_ready), 64'd1);

    // Good reads.
    send(3'd0, 8'd100, 6'd2, 32'h0000_0002, 1'b0, 1'b1);
    wait_idle();
    send(3'd2, 8'd69, 6'd32, 32'h403C_8000, 1'b0, 1'b1);
    wait_idle();
    send(3'd0, 8'd229, 6'd32, 32'h0044_6F77, 1'b0, 1'b1);
    wait_idle();
    send(3'd3, 8'd5, 6'd3, 32'h0000_0003, 1'b0, 1'b1);
    wait_idle();
    send(3'd1, 8'd0, 6'd1, 32'h0000_0001, 1'b0, 1'b1);
    wait_idle();

    // Error cases.
    send(3'd5, 8'd10, 6'd4, 32'h0, 1'b1, 1'b1);
    wait_idle();
    send(3'd0, 8'd10, 6'd12, 32'h0, 1'b1, 1'b1);
    wait_idle();
    send(3'd0, 8'd10, 6'd0, 32'h0, 1'b1, 1'b1);
    wait_idle();
    send(3'd0, 8'd40, 6'd33, 32'h0, 1'b1, 1'b1);
    wait_idle();
    send(3'd0, 8'd230, 6'd1, 32'h0, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: response held for 5 cycles with req_ready low.
    rsp_ready = 1'b0;
    send(3'd2, 8'd69, 6'd32, 32'h403C_8000, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    repeat (5) begin
      @(posedge CLK); #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    wait_idle();

    // Snapshot: comp0 changes during SHIFT must not reach the result.
    comp0_saved = comp0;
    send(3'd0, 8'd229, 6'd32, 32'h0044_6F77, 1'b0, 1'b1);
    repeat (3) begin @(posedge CLK); #1; end
    comp0[229:102] = '1;
    wait_idle();
    comp0 = comp0_saved;

    // Duplicate id 000 on comp1: comp0 wins, id 001 no longer exists.
    comp1_saved = comp1;
    comp1[2:0] = 3'd0;
    comp1[229:102] = '1;
    send(3'd0, 8'd229, 6'd32, 32'h0044_6F77, 1'b0, 1'b1);
    wait_idle();
    send(3'd1, 8'd0, 6'd1, 32'h0, 1'b1, 1'b1);
    wait_idle();
    comp1 = comp1_saved;

    // Reset mid-SHIFT: request dropped, no response ever appears.
    send(3'd2, 8'd69, 6'd32, 32'h0, 1'b0, 1'b0);
    repeat (4) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_value", 64'(rsp_value), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    repeat (40) begin @(posedge CLK); #1; end
    send(3'd0, 8'd100, 6'd2, 32'h0000_0002, 1'b0, 1'b1);
    wait_idle();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
